// File: rtl/load_use_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared constants and scoreboard entry type for the load-use
//            hazard controller.
// Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int REG_X0         = 0;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
  } sb_entry_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/load_use_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : load_use_hazard_ctrl_if
// Brief    : ID-stage hazard inputs and pipeline hold/bubble/flush controls.
// Revision : 1.0  initial release
// ============================================================================
interface load_use_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);

  logic [REG_ADDR_W-1:0] IF_ID_rs1;
  logic [REG_ADDR_W-1:0] IF_ID_rs2;
  logic                  IF_ID_uses_rs1;
  logic                  IF_ID_uses_rs2;
  logic                  ID_EX_MemRead;
  logic [REG_ADDR_W-1:0] ID_EX_rd;
  logic                  mem_ready;
  logic                  branch_flush;
  logic                  PC_Stall;
  logic                  IF_ID_Stall;
  logic                  ID_EX_Bubble;
  logic                  IF_ID_Flush;
  logic                  pipe_freeze;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs1, IF_ID_uses_rs2,
    output ID_EX_MemRead, ID_EX_rd, mem_ready, branch_flush,
    input  PC_Stall, IF_ID_Stall, ID_EX_Bubble, IF_ID_Flush,
    input  pipe_freeze, stall_count
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs1, IF_ID_uses_rs2,
    input  ID_EX_MemRead, ID_EX_rd, mem_ready, branch_flush,
    output PC_Stall, IF_ID_Stall, ID_EX_Bubble, IF_ID_Flush,
    output pipe_freeze, stall_count
  );

endinterface : load_use_hazard_ctrl_if
`default_nettype wire

// File: rtl/load_use_hazard_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : load_scoreboard
// Brief    : LOAD_LAT-1 stage delay line of in-flight loads with per-stage
//            destination match against the ID sources.
// Revision : 1.0  initial release
// ============================================================================
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter  int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter  int LOAD_LAT   = 1,
  localparam int SB_W       = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  i_advance,
  input  wire logic                  i_ex_mem_read,
  input  wire logic [REG_ADDR_W-1:0] i_ex_rd,
  input  wire logic [REG_ADDR_W-1:0] i_rs1,
  input  wire logic [REG_ADDR_W-1:0] i_rs2,
  output logic      [SB_W-1:0]       o_hit_rs1,
  output logic      [SB_W-1:0]       o_hit_rs2
);

  if (LOAD_LAT > 1) begin : g_stages
    sb_entry_t r_stage [SB_W];

    // Holds while frozen so the remaining latency survives a memory wait.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < SB_W; k++) r_stage[k] <= '0;
      end else if (i_advance) begin
        r_stage[0].valid <= i_ex_mem_read && (i_ex_rd != REG_ADDR_W'(REG_X0));
        r_stage[0].rd    <= REG_ADDR_W_DEF'(i_ex_rd);
        for (int k = 1; k < SB_W; k++) r_stage[k] <= r_stage[k-1];
      end
    end

    always_comb begin
      o_hit_rs1 = '0;
      o_hit_rs2 = '0;
      for (int k = 0; k < SB_W; k++) begin
        o_hit_rs1[k] = r_stage[k].valid && (r_stage[k].rd == REG_ADDR_W_DEF'(i_rs1));
        o_hit_rs2[k] = r_stage[k].valid && (r_stage[k].rd == REG_ADDR_W_DEF'(i_rs2));
      end
    end
  end else begin : g_no_stages
    logic w_unused_nostage;
    assign w_unused_nostage = ^{clk, reset, i_advance, i_ex_mem_read,
                                i_ex_rd, i_rs1, i_rs2};
    assign o_hit_rs1 = '0;
    assign o_hit_rs2 = '0;
  end

endmodule : load_scoreboard
`default_nettype wire

// File: rtl/load_use_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : load_use_hazard_ctrl
// Brief    : Prioritised freeze/flush/load-use stall decode with a
//            configurable-latency load scoreboard. Macro LOAD_USE_PERF_CNT_EN
//            builds the saturating stall_count register.
// Revision : 1.0  initial release
// ============================================================================
module load_use_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input wire logic              clk,
  input wire logic              reset,
  load_use_hazard_ctrl_if.slave bus
);

  localparam int SB_W = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  logic            w_freeze;
  logic            w_flush;
  logic            w_use1;
  logic            w_use2;
  logic            w_ex_hit;
  logic            w_sb_hit;
  logic            w_load_use;
  logic [SB_W-1:0] w_hit_rs1;
  logic [SB_W-1:0] w_hit_rs2;

  load_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .LOAD_LAT   (LOAD_LAT)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .i_advance     (~w_freeze),
    .i_ex_mem_read (bus.ID_EX_MemRead),
    .i_ex_rd       (bus.ID_EX_rd),
    .i_rs1         (bus.IF_ID_rs1),
    .i_rs2         (bus.IF_ID_rs2),
    .o_hit_rs1     (w_hit_rs1),
    .o_hit_rs2     (w_hit_rs2)
  );

  assign w_freeze = ~bus.mem_ready;
  assign w_flush  = bus.branch_flush;
  assign w_use1   = bus.IF_ID_uses_rs1 && (bus.IF_ID_rs1 != REG_ADDR_W'(REG_X0));
  assign w_use2   = bus.IF_ID_uses_rs2 && (bus.IF_ID_rs2 != REG_ADDR_W'(REG_X0));

  assign w_ex_hit = bus.ID_EX_MemRead &&
                    ((w_use1 && (bus.IF_ID_rs1 == bus.ID_EX_rd)) ||
                     (w_use2 && (bus.IF_ID_rs2 == bus.ID_EX_rd)));
  assign w_sb_hit = (w_use1 && (|w_hit_rs1)) || (w_use2 && (|w_hit_rs2));
  assign w_load_use = w_ex_hit || w_sb_hit;

  // Reset forces every control low so an in-progress stall is dropped at once.
  always_comb begin
    bus.pipe_freeze  = 1'b0;
    bus.PC_Stall     = 1'b0;
    bus.IF_ID_Stall  = 1'b0;
    bus.ID_EX_Bubble = 1'b0;
    bus.IF_ID_Flush  = 1'b0;
    if (!reset) begin
      if (w_freeze) begin
        bus.pipe_freeze = 1'b1;
        bus.PC_Stall    = 1'b1;
        bus.IF_ID_Stall = 1'b1;
      end else if (w_flush) begin
        bus.IF_ID_Flush  = 1'b1;
        bus.ID_EX_Bubble = 1'b1;
      end else if (w_load_use) begin
        bus.PC_Stall     = 1'b1;
        bus.IF_ID_Stall  = 1'b1;
        bus.ID_EX_Bubble = 1'b1;
      end
    end
  end

`ifdef LOAD_USE_PERF_CNT_EN
  logic             w_count_en;
  logic [CNT_W-1:0] r_stall_count;

  assign w_count_en = w_load_use && !w_freeze && !w_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_count_en && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign bus.stall_count = r_stall_count;
`else
  assign bus.stall_count = '0;
`endif

endmodule : load_use_hazard_ctrl
`default_nettype wire

// File: doc/load_use_hazard_ctrl.md
# load_use_hazard_ctrl

Parametrised load-use hazard and stall controller for the RV32 pipeline. It sits beside the ID stage and replaces the single-cycle load-use check with a configurable-latency scoreboard of in-flight loads. It also handles data-memory wait states and branch flushes, and generates every PC, IF/ID and ID/EX hold, bubble and flush control from one prioritised decision.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_LAT, 1, cycles between a load leaving EX and its data becoming forwardable; range 1..8.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- IF_ID_rs1, IF_ID_rs2  in  REG_ADDR_W  source registers of the ID instruction.
- IF_ID_uses_rs1, IF_ID_uses_rs2  in  1  the ID instruction actually reads that source.
- ID_EX_MemRead  in  1  the EX instruction is a load.
- ID_EX_rd  in  REG_ADDR_W  destination register of the EX instruction.
- mem_ready  in  1  data memory completes this cycle; 0 freezes the pipeline.
- branch_flush  in  1  taken branch or jump resolved in EX.
- PC_Stall  out  1  hold the PC.
- IF_ID_Stall  out  1  hold the IF/ID register.
- ID_EX_Bubble  out  1  load a NOP into ID/EX.
- IF_ID_Flush  out  1  clear IF/ID.
- pipe_freeze  out  1  hold every pipeline register, including ID/EX and later.
- stall_count  out  CNT_W  number of load-use stall cycles, saturating.

## Operation
Decision priority is freeze, then flush, then load-use stall, then normal.

- **Freeze:** when mem_ready=0, pipe_freeze=1, PC_Stall=1 and IF_ID_Stall=1. ID_EX_Bubble=0, IF_ID_Flush=0, the scoreboard holds and the counter holds. branch_flush is ignored because the branch stays in EX and re-asserts.
- **Flush:** when branch_flush=1 and there is no freeze, IF_ID_Flush=1 and ID_EX_Bubble=1. PC_Stall=0 and IF_ID_Stall=0, so a load-use match is discarded. The counter does not increment.
- **Load-use stall:** a stall is raised when a used source (uses_rsN=1) is nonzero and matches either of these:
  - ID_EX_rd, while ID_EX_MemRead=1;
  - any valid scoreboard stage.
- On a stall, PC_Stall=1, IF_ID_Stall=1 and ID_EX_Bubble=1.
- A source of x0 never matches. A match on an unused source never stalls.
- **Scoreboard:** a delay line of LOAD_LAT-1 stages, each holding {valid, rd}.
  - It shifts on every non-frozen edge.
  - Stage 1 captures {ID_EX_MemRead && rd!=0, ID_EX_rd}.
  - Stage k holds the load that left EX k advancing cycles ago.
  - The last stage retires.
  - When LOAD_LAT=1 there are no stages, and the behaviour is the classic one-bubble stall.
- **Result:** a load in EX at cycle t delays a dependent instruction in ID by exactly LOAD_LAT stall cycles. The dependent instruction enters EX at t+LOAD_LAT+1, not counting freeze cycles.
- **Simultaneous hits:** when both sources match different loads, the stall lasts until the youngest match retires.

## Timing
- All control outputs are combinational from the inputs and the scoreboard, and are valid in the same cycle.
- The scoreboard and stall_count update on the rising edge of clk.
- Reset values:
  - all scoreboard stages invalid;
  - stall_count=0;
  - with inputs idle, every output is 0.
- A reset mid-stall aborts the stall immediately, and pending loads are forgotten.
- stall_count increments by 1 on each edge where the load-use stall is active and there is neither a freeze nor a flush. It saturates at all-ones with no wrap-around.
- Depth is never exceeded: at most one load enters per cycle and LOAD_LAT-1 stages cover the full window, so there is no full condition.

## Configuration
- LOAD_USE_PERF_CNT_EN defined: the stall_count register and its logic are built.
- LOAD_USE_PERF_CNT_EN undefined: the port remains but is tied to 0 and no flops are generated. Hazard behaviour is identical in both cases.

## Structure
- Shared package hazard_pkg holds:
  - REG_ADDR_W default;
  - constant REG_X0 = 0;
  - the scoreboard entry struct {valid, rd}.
- Sub-module load_scoreboard holds the delay line, its freeze-hold logic and a per-stage match vector against rs1/rs2.
- The top level holds the priority decode and the counter.

## Test plan
- LOAD_LAT=1: lw x5 in EX, ID uses rs1=x5 -> one cycle with PC_Stall/IF_ID_Stall/ID_EX_Bubble=1, then 0; stall_count=1.
- LOAD_LAT=3: lw x7 in EX at t, dependent in ID uses rs2=x7 -> stall at t, t+1 and t+2; deasserted at t+3; stall_count=3.
- Matches that must not stall -> no stall, stall_count unchanged:
  - lw x0 with rs1=x0;
  - lw x6 with rs2=x6 but uses_rs2=0.
- LOAD_LAT=3: mem_ready=0 for 2 cycles while stage 1 holds x9 and ID uses x9 -> pipe_freeze=1 and ID_EX_Bubble=0 for 2 cycles. The scoreboard is unchanged. After resume the stall continues for exactly the remaining 2 cycles.
- branch_flush=1 in the same cycle as a load-use match on x4 -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Stall=0, stall_count unchanged.
- LOAD_LAT=4: reset asserted mid-stall with 3 valid stages -> all outputs 0 in the reset cycle; after release an ID use of those registers does not stall.
